// File: rtl/de_inst_align.sv
// Instruction aligner: buffers 64-bit fetch words as 16-bit parcels and hands one
// 16/32/64-bit instruction per cycle to decode, MSB-aligned on a 64-bit bus.
module de_inst_align #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [63:0]     fetchWord,
  input  logic            fetchValid,
  output logic            fetchReady,
  input  logic            flush,
  input  logic [PC_W-1:0] flushPc,
  output logic [63:0]     instOut,
  output logic [1:0]      instLen,
  output logic [PC_W-1:0] instPc,
  output logic            instValid,
  input  logic            instReady
);

  // Parcel count for an instruction from its first parcel.
  function automatic logic [2:0] parcelNeed(input logic [15:0] head);
    if (!head[15])      return 3'd1;
    else if (!head[14]) return 3'd2;
    else                return 3'd4;
  endfunction

  logic [7:0][15:0] bufQ;
  logic [7:0][15:0] shifted;
  logic [7:0][15:0] nextBuf;
  logic [3:0]       cntQ;
  logic [1:0]       skipQ;
  logic [PC_W-1:0]  pcQ;

  logic [2:0]       need;
  logic [3:0]       popN;
  logic [3:0]       base;
  logic [3:0]       shIdx;
  logic [3:0]       wIdx;
  logic [3:0]       nextCnt;
  logic             doPush;
  logic             doPop;
  logic [PC_W-1:0]  flushPcAligned;

  assign flushPcAligned = flushPc & ~PC_W'(1);

  always_comb begin
    need      = parcelNeed(bufQ[0]);
    instValid = (cntQ != 4'd0) && (cntQ >= {1'b0, need});
    instPc    = pcQ;
    instOut   = 64'h0;
    instLen   = 2'd0;
    if (instValid) begin
      case (need)
        3'd1: begin
          instOut = {bufQ[0], 48'h0};
          instLen = 2'd0;
        end
        3'd2: begin
          instOut = {bufQ[0], bufQ[1], 32'h0};
          instLen = 2'd1;
        end
        default: begin
          instOut = {bufQ[0], bufQ[1], bufQ[2], bufQ[3]};
          instLen = 2'd2;
        end
      endcase
    end
  end

  // Ready depends on registered occupancy only, never on a same-cycle pop.
  assign fetchReady = rst_n && (cntQ <= 4'd4) && !flush;
  assign doPush     = fetchValid && fetchReady;
  assign doPop      = instValid && instReady && !flush;

  always_comb begin
    popN    = doPop ? {1'b0, need} : 4'd0;
    base    = cntQ - popN;
    shIdx   = 4'd0;
    wIdx    = 4'd0;
    shifted = '0;
    for (int i = 0; i < 8; i++) begin
      shIdx = 4'(i) + popN;
      if (!shIdx[3]) shifted[i] = bufQ[shIdx[2:0]];
    end
    nextBuf = shifted;
    nextCnt = base;
    if (doPush) begin
      // Parcels before skip belong to a flush target's predecessor and are dropped.
      for (int k = 0; k < 4; k++) begin
        if (2'(k) >= skipQ) begin
          wIdx = base + 4'(k) - {2'b00, skipQ};
          nextBuf[wIdx[2:0]] = fetchWord[63-16*k -: 16];
        end
      end
      nextCnt = base + 4'd4 - {2'b00, skipQ};
    end
  end

  always_ff @(posedge clk) begin
    bufQ <= nextBuf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cntQ  <= 4'd0;
      skipQ <= 2'd0;
      pcQ   <= RESET_PC;
    end else if (flush) begin
      cntQ  <= 4'd0;
      skipQ <= flushPcAligned[2:1];
      pcQ   <= flushPcAligned;
    end else begin
      cntQ <= nextCnt;
      if (doPush) skipQ <= 2'd0;
      if (doPop)  pcQ   <= pcQ + PC_W'({need, 1'b0});
    end
  end

endmodule

// File: tb/tb_de_inst_align.sv
// Directed bench for de_inst_align: expected instructions are queued when the
// stimulus is driven and compared as decode consumes them.
module tb_de_inst_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] fetchWord;
  logic        fetchValid;
  logic        fetchReady;
  logic        flush;
  logic [63:0] flushPc;
  logic [63:0] instOut;
  logic [1:0]  instLen;
  logic [63:0] instPc;
  logic        instValid;
  logic        instReady;

  typedef struct {
    logic [63:0] inst;
    logic [1:0]  len;
    logic [63:0] pc;
  } exp_t;

  exp_t sb[$];
  int   nCmp = 0;
  int   nErr = 0;
  bit   acc;

  always #5 clk = ~clk;

  de_inst_align #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetchWord(fetchWord), .fetchValid(fetchValid), .fetchReady(fetchReady),
    .flush(flush), .flushPc(flushPc),
    .instOut(instOut), .instLen(instLen), .instPc(instPc),
    .instValid(instValid), .instReady(instReady)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect16(input logic [15:0] p, input logic [63:0] pc);
    exp_t e;
    e.inst = {p, 48'h0}; e.len = 2'd0; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic expectInst(input logic [63:0] inst, input logic [1:0] len, input logic [63:0] pc);
    exp_t e;
    e.inst = inst; e.len = len; e.pc = pc;
    sb.push_back(e);
  endtask

  // Sample at negedge, let the posedge happen, return 1 time unit after it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (instValid && instReady && !flush) begin
      if (sb.size() == 0) begin
        chk("unexpected_inst", 64'(instValid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("instOut", instOut, e.inst);
        chk("instLen", 64'(instLen), 64'(e.len));
        chk("instPc", instPc, e.pc);
      end
    end
    if (fetchValid && fetchReady) acc = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [63:0] w);
    fetchWord  = w;
    fetchValid = 1'b1;
    acc        = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick();
    chk("push_accept", 64'(acc), 64'd1);
    fetchValid = 1'b0;
  endtask

  task automatic doFlush(input logic [63:0] p);
    flush   = 1'b1;
    flushPc = p;
    tick();
    flush   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; fetchWord = '0; fetchValid = 1'b0;
    flush = 1'b0; flushPc = '0; instReady = 1'b0;
    tick(); tick();
    chk("rst_fetchReady_low", 64'(fetchReady), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_instValid", 64'(instValid), 64'd0);
    chk("rst_instOut", instOut, 64'd0);
    chk("rst_instLen", 64'(instLen), 64'd0);
    chk("rst_instPc", instPc, 64'd0);
    chk("rst_fetchReady", 64'(fetchReady), 64'd1);

    // Four 16-bit instructions from one word, one per cycle.
    expect16(16'h1111, 64'h0); expect16(16'h2222, 64'h2);
    expect16(16'h3333, 64'h4); expect16(16'h4444, 64'h6);
    instReady = 1'b1;
    pushWord(64'h1111_2222_3333_4444);
    chk("t1_latency", 64'(instValid), 64'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_one_per_cycle", 64'(sb.size()), 64'd0);
    chk("t1_idle", 64'(instValid), 64'd0);
    chk("t1_pc", instPc, 64'h8);

    // 32-bit then a 64-bit instruction spanning two words.
    doFlush(64'h0);
    expectInst(64'h8A00_0001_0000_0000, 2'd1, 64'h0);
    expectInst(64'hC000_0000_0000_0002, 2'd2, 64'h4);
    expect16(16'h1234, 64'hC); expect16(16'h5678, 64'hE);
    pushWord(64'h8A00_0001_C000_0000);
    tick();
    chk("t2_partial_invalid", 64'(instValid), 64'd0);
    tick();
    chk("t2_partial_invalid2", 64'(instValid), 64'd0);
    pushWord(64'h0000_0002_1234_5678);
    drain();

    // Full buffer back-pressure, then recovery without losing parcels.
    instReady = 1'b0;
    pushWord(64'hC111_2222_3333_4444);
    pushWord(64'h0AAA_0BBB_0CCC_0DDD);
    chk("t3_full_ready", 64'(fetchReady), 64'd0);
    fetchWord = 64'h0123_0456_0789_0ABC; fetchValid = 1'b1; acc = 1'b0;
    tick(); tick();
    chk("t3_word_held", 64'(acc), 64'd0);
    expectInst(64'hC111_2222_3333_4444, 2'd2, 64'h10);
    expect16(16'h0AAA, 64'h18); expect16(16'h0BBB, 64'h1A);
    expect16(16'h0CCC, 64'h1C); expect16(16'h0DDD, 64'h1E);
    expect16(16'h0123, 64'h20); expect16(16'h0456, 64'h22);
    expect16(16'h0789, 64'h24); expect16(16'h0ABC, 64'h26);
    instReady = 1'b1;
    tick();
    chk("t3_ready_returns", 64'(fetchReady), 64'd1);
    pushWord(64'h0123_0456_0789_0ABC);
    drain();

    // Flush to a mid-word PC discards stale parcels and skips leading ones.
    instReady = 1'b0;
    pushWord(64'h1111_2222_3333_4444);
    doFlush(64'h106);
    chk("t4_flush_invalid", 64'(instValid), 64'd0);
    chk("t4_flush_pc", instPc, 64'h106);
    expect16(16'h1234, 64'h106);
    instReady = 1'b1;
    pushWord(64'hAAAA_BBBB_CCCC_1234);
    drain();
    tick(); tick();
    chk("t4_only_one", 64'(instValid), 64'd0);
    chk("t4_pc_after", instPc, 64'h108);

    // Flush beats a same-cycle fetch word and pop.
    instReady = 1'b0;
    pushWord(64'h1111_2222_3333_4444);
    fetchWord = 64'h5555_6666_7777_8888; fetchValid = 1'b1; acc = 1'b0;
    instReady = 1'b1; flush = 1'b1; flushPc = 64'h40;
    tick();
    flush = 1'b0; fetchValid = 1'b0;
    chk("t5_not_accepted", 64'(acc), 64'd0);
    chk("t5_no_pop_valid", 64'(instValid), 64'd0);
    chk("t5_pc", instPc, 64'h40);
    expect16(16'h0001, 64'h40); expect16(16'h0002, 64'h42);
    expect16(16'h0003, 64'h44); expect16(16'h0004, 64'h46);
    pushWord(64'h0001_0002_0003_0004);
    drain();

    // Reset mid-stream with five parcels buffered.
    instReady = 1'b0;
    pushWord(64'h0011_0022_0033_0044);
    expect16(16'h0011, 64'h48); expect16(16'h0022, 64'h4A); expect16(16'h0033, 64'h4C);
    instReady = 1'b1;
    tick(); tick(); tick();
    instReady = 1'b0;
    pushWord(64'h0055_0066_0077_0088);
    chk("t6_pre_valid", 64'(instValid), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_valid", 64'(instValid), 64'd0);
    chk("t6_rst_out", instOut, 64'd0);
    chk("t6_rst_len", 64'(instLen), 64'd0);
    chk("t6_rst_pc", instPc, 64'h0);
    chk("t6_rst_ready", 64'(fetchReady), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("t6_ready_after", 64'(fetchReady), 64'd1);
    expectInst(64'h9999_0001_0000_0000, 2'd1, 64'h0);
    expect16(16'h7777, 64'h4); expect16(16'h0002, 64'h6);
    instReady = 1'b1;
    pushWord(64'h9999_0001_7777_0002);
    drain();
    tick(); tick();
    chk("t6_final_idle", 64'(instValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
